// File: rtl/serial_link_fifo.sv
// serial_link_fifo
//   Single-clock serial link. A TX FIFO feeds a framed shifter (sclk_out/cs_out/sdo_out);
//   an oversampling deframer on sclk_in/cs_in/sdi_in fills an RX FIFO. Sticky error flags
//   and a maskable one-clk interrupt pulse.
//   Optional feature macro: SERIAL_LINK_PARITY_EN (append/check an even-parity bit).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tx_rst, rx_rst           synchronous soft resets of the TX half / RX half
//   div                      sclk half-period is div+1 clk (div >= 2), latched per frame
//   tx_wr, tx_data           TX FIFO push; tx_full, tx_empty (FIFO empty and FSM idle)
//   rx_rd, rx_data           RX FIFO show-ahead pop/head; rx_valid = not empty
//   err_clr, err             sticky {par_err, frm_err, ovr_err}
//   irq_en, irq              {tx_done, rx_not_empty} enables, one-clk registered pulse
//   sclk_out, cs_out, sdo_out    serial transmit lines
//   sclk_in, cs_in, sdi_in       asynchronous serial receive lines
module serial_link_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_W      = 8,
   parameter int unsigned LSB_FIRST  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_rst,
   input  logic              rx_rst,
   input  logic [DIV_W-1:0]  div,
   input  logic              tx_wr,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_full,
   output logic              tx_empty,
   input  logic              rx_rd,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              err_clr,
   output logic [2:0]        err,
   input  logic [1:0]        irq_en,
   output logic              irq,
   output logic              sclk_out,
   output logic              cs_out,
   output logic              sdo_out,
   input  logic              sclk_in,
   input  logic              cs_in,
   input  logic              sdi_in
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef SERIAL_LINK_PARITY_EN
   localparam int unsigned N = DATA_W + 1;
`else
   localparam int unsigned N = DATA_W;
`endif
   localparam int unsigned BW = $clog2(N + 1);  // TX bit index 0..N (N = trailing low phase)
   localparam int unsigned CW = $clog2(N + 2);  // RX bit count 0..N+1

   typedef enum logic [1:0] {TxIdle, TxLoad, TxShift, TxGap} tx_state_e;

   // ---------------- TX FIFO ----------------
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [AW:0]       tx_wp_q, tx_rp_q;
   logic              tx_fifo_empty, tx_push, tx_pop;
   tx_state_e         tx_state_q;

   assign tx_fifo_empty = (tx_wp_q == tx_rp_q);
   assign tx_full = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
   assign tx_push = tx_wr && !tx_full;
   assign tx_pop  = (tx_state_q == TxLoad);  // LOAD is only entered with the FIFO non-empty
   assign tx_empty = tx_fifo_empty && (tx_state_q == TxIdle);

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= tx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wp_q <= '0;
         tx_rp_q <= '0;
      end else if (tx_rst) begin
         tx_wp_q <= '0;
         tx_rp_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      end
   end

   // Frame in transmission order: index 0 goes out first, parity (if any) last.
   logic [DATA_W-1:0] tx_head;
   logic [N-1:0]      tx_frame;
   assign tx_head = tx_mem[tx_rp_q[AW-1:0]];

   always_comb begin
      tx_frame = '0;
      for (int k = 0; k < DATA_W; k++) begin
         if (LSB_FIRST != 0) tx_frame[k] = tx_head[k];
         else                tx_frame[k] = tx_head[DATA_W-1-k];
      end
`ifdef SERIAL_LINK_PARITY_EN
      tx_frame[N-1] = ^tx_head;
`endif
   end

   // ---------------- TX FSM ----------------
   // Line outputs are registered from the bit/phase counters, so they trail the counters
   // by one clk; bit 0 becomes visible on the first clk after LOAD.
   logic [N-1:0]     tx_sr_q;
   logic [DIV_W-1:0] div_q;
   logic [BW-1:0]    bit_q;
   logic [DIV_W:0]   ph_q;
   logic             sclk_q, cs_q, sdo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_sr_q    <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         ph_q       <= '0;
         sclk_q     <= 1'b0;
         cs_q       <= 1'b0;
         sdo_q      <= 1'b0;
      end else if (tx_rst) begin
         tx_state_q <= TxIdle;
         tx_sr_q    <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         ph_q       <= '0;
         sclk_q     <= 1'b0;
         cs_q       <= 1'b0;
         sdo_q      <= 1'b0;
      end else begin
         unique case (tx_state_q)
            TxIdle: begin
               if (!tx_fifo_empty) tx_state_q <= TxLoad;
            end
            TxLoad: begin
               tx_sr_q    <= tx_frame;
               div_q      <= div;
               bit_q      <= '0;
               ph_q       <= '0;
               tx_state_q <= TxShift;
            end
            TxShift: begin
               cs_q   <= 1'b1;
               sclk_q <= (bit_q != BW'(N)) && (ph_q > {1'b0, div_q});
               if ((ph_q == '0) && (bit_q != BW'(N))) begin
                  sdo_q   <= tx_sr_q[0];
                  tx_sr_q <= tx_sr_q >> 1;
               end
               if (bit_q == BW'(N)) begin
                  // Trailing low phase keeps cs high past the last sclk fall.
                  if (ph_q == {1'b0, div_q}) begin
                     ph_q       <= '0;
                     tx_state_q <= TxGap;
                  end else begin
                     ph_q <= ph_q + 1'b1;
                  end
               end else if (ph_q == {div_q, 1'b1}) begin
                  ph_q  <= '0;
                  bit_q <= bit_q + 1'b1;
               end else begin
                  ph_q <= ph_q + 1'b1;
               end
            end
            TxGap: begin
               cs_q   <= 1'b0;
               sclk_q <= 1'b0;
               sdo_q  <= 1'b0;
               if (ph_q == {div_q, 1'b1}) begin
                  ph_q       <= '0;
                  tx_state_q <= tx_fifo_empty ? TxIdle : TxLoad;
               end else begin
                  ph_q <= ph_q + 1'b1;
               end
            end
            default: tx_state_q <= TxIdle;
         endcase
      end
   end

   assign sclk_out = sclk_q;
   assign cs_out   = cs_q;
   assign sdo_out  = sdo_q;

   // ---------------- RX synchronisers and deframer ----------------
   logic [2:0] sclk_sh_q, cs_sh_q;
   logic [1:0] sdi_sh_q;
   logic       sclk_rise, cs_rise, cs_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sh_q <= '0;
         cs_sh_q   <= '0;
         sdi_sh_q  <= '0;
      end else begin
         sclk_sh_q <= {sclk_sh_q[1:0], sclk_in};
         cs_sh_q   <= {cs_sh_q[1:0], cs_in};
         sdi_sh_q  <= {sdi_sh_q[0], sdi_in};
      end
   end

   assign sclk_rise = sclk_sh_q[1] && !sclk_sh_q[2];
   assign cs_rise   = cs_sh_q[1] && !cs_sh_q[2];
   assign cs_fall   = !cs_sh_q[1] && cs_sh_q[2];

   // Bits shift in from the top, so after N bits arrival order k sits at index k.
   logic [N-1:0]  rx_sr_q;
   logic [CW-1:0] rx_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sr_q  <= '0;
         rx_cnt_q <= '0;
      end else if (rx_rst) begin
         rx_sr_q  <= '0;
         rx_cnt_q <= '0;
      end else if (cs_rise) begin
         rx_cnt_q <= '0;
      end else if (sclk_rise && cs_sh_q[1]) begin
         rx_sr_q <= {sdi_sh_q[1], rx_sr_q[N-1:1]};
         if (rx_cnt_q != CW'(N + 1)) rx_cnt_q <= rx_cnt_q + 1'b1;
      end
   end

   logic [DATA_W-1:0] rx_word;
   logic              par_bad, frame_ok, frm_new, ovr_new, rx_push, rx_pop, rx_fifo_full;

   always_comb begin
      rx_word = '0;
      for (int k = 0; k < DATA_W; k++) begin
         if (LSB_FIRST != 0) rx_word[k] = rx_sr_q[k];
         else                rx_word[DATA_W-1-k] = rx_sr_q[k];
      end
   end

`ifdef SERIAL_LINK_PARITY_EN
   assign par_bad = rx_sr_q[N-1] ^ (^rx_word);
`else
   assign par_bad = 1'b0;
`endif

   assign frame_ok = cs_fall && (rx_cnt_q == CW'(N));
   assign frm_new  = cs_fall && (rx_cnt_q != CW'(N));
   assign ovr_new  = frame_ok && !par_bad && rx_fifo_full;
   assign rx_push  = frame_ok && !par_bad && !rx_fifo_full;

   // ---------------- RX FIFO ----------------
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [AW:0]       rx_wp_q, rx_rp_q;

   assign rx_valid     = (rx_wp_q != rx_rp_q);
   assign rx_fifo_full = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
   assign rx_pop       = rx_rd && rx_valid;
   assign rx_data      = rx_valid ? rx_mem[rx_rp_q[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wp_q <= '0;
         rx_rp_q <= '0;
      end else if (rx_rst) begin
         rx_wp_q <= '0;
         rx_rp_q <= '0;
      end else begin
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      end
   end

   // ---------------- Sticky errors ----------------
   // Clear first, then OR in new events, so a same-cycle new error survives err_clr.
   logic [1:0] err_q;  // {frm, ovr}

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         err_q <= '0;
      else if (rx_rst) err_q <= '0;
      else             err_q <= (err_clr ? 2'b00 : err_q) | {frm_new, ovr_new};
   end

`ifdef SERIAL_LINK_PARITY_EN
   logic par_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         par_err_q <= 1'b0;
      else if (rx_rst) par_err_q <= 1'b0;
      else             par_err_q <= (par_err_q && !err_clr) || (frame_ok && !frm_new && par_bad);
   end

   assign err = {par_err_q, err_q};
`else
   assign err = {1'b0, err_q};
`endif

   // ---------------- Interrupt ----------------
   logic ev_rx, ev_tx, ev_rx_q, ev_tx_q, irq_q;

   assign ev_rx = rx_valid && irq_en[0];
   assign ev_tx = tx_empty && irq_en[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_rx_q <= 1'b0;
         ev_tx_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         ev_rx_q <= ev_rx;
         ev_tx_q <= ev_tx;
         irq_q   <= (ev_rx && !ev_rx_q) || (ev_tx && !ev_tx_q);
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_serial_link_fifo.sv
// Bench for serial_link_fifo (DATA_W=8, FIFO_DEPTH=16, DIV_W=8, LSB_FIRST=1).
// Expected values come from a word-level model: queues of pushed words, bit k of a
// word is (w >> k) & 1, bit period is 2*(div+1), and the FIFO holds at most 16 words.
module tb_serial_link_fifo;
`ifdef SERIAL_LINK_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       clk = 1'b0;
   logic       rst, tx_rst, rx_rst, tx_wr, rx_rd, err_clr;
   logic [7:0] div, tx_data, rx_data;
   logic       tx_full, tx_empty, rx_valid, irq;
   logic [2:0] err;
   logic [1:0] irq_en;
   logic       sclk_out, cs_out, sdo_out, sclk_in, cs_in, sdi_in;
   logic       loop, ext_sclk, ext_cs, ext_sdi;

   assign sclk_in = loop ? sclk_out : ext_sclk;
   assign cs_in   = loop ? cs_out   : ext_cs;
   assign sdi_in  = loop ? sdo_out  : ext_sdi;

   serial_link_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(8), .LSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .tx_rst(tx_rst), .rx_rst(rx_rst), .div(div),
      .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty),
      .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
      .err_clr(err_clr), .err(err), .irq_en(irq_en), .irq(irq),
      .sclk_out(sclk_out), .cs_out(cs_out), .sdo_out(sdo_out),
      .sclk_in(sclk_in), .cs_in(cs_in), .sdi_in(sdi_in)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int irq_cnt = 0;
   int cyc = 0;
   logic sclk_prev = 1'b0;
   int   rise_t[$];
   logic rise_b[$];
   logic [7:0] expq[$];

   always @(negedge clk) begin
      cyc++;
      if (irq) irq_cnt++;
      if (sclk_out && !sclk_prev) begin
         rise_t.push_back(cyc);
         rise_b.push_back(sdo_out);
      end
      sclk_prev = sclk_out;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] w);
      tx_data = w;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr   = 1'b0;
   endtask

   task automatic send_ext(input logic [15:0] bits, input int nbits);
      ext_cs = 1'b1;
      tick(4);
      for (int k = 0; k < nbits; k++) begin
         ext_sdi  = bits[k];
         tick(4);
         ext_sclk = 1'b1;
         tick(4);
         ext_sclk = 1'b0;
      end
      tick(4);
      ext_cs = 1'b0;
      tick(8);
   endtask

   task automatic test_reset;
      rst = 1'b1; tx_rst = 1'b0; rx_rst = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0; err_clr = 1'b0;
      div = 8'd3; tx_data = '0; irq_en = 2'b00; loop = 1'b0;
      ext_sclk = 1'b0; ext_cs = 1'b0; ext_sdi = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      tests++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL reset_tx_empty: got %b want 1", tx_empty); end
      tests++; if (tx_full !== 1'b0) begin fails++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      tests++; if (err !== 3'b000) begin fails++; $display("FAIL reset_err: got %b want 000", err); end
      tests++; if ({irq, cs_out, sclk_out, sdo_out} !== 4'b0000) begin
         fails++; $display("FAIL reset_lines: got irq/cs/sclk/sdo=%b want 0000", {irq, cs_out, sclk_out, sdo_out});
      end
   endtask

   task automatic test_loopback_a5;
      int unsigned wv = 32'hA5;
      loop = 1'b1; div = 8'd3; irq_en = 2'b01;
      tick(2);
      irq_cnt = 0; rise_t.delete(); rise_b.delete();
      push(8'hA5);
      tick(2);
      tests++; if (cs_out !== 1'b0) begin fails++; $display("FAIL cs_latency_early: got %b want 0", cs_out); end
      tick(1);
      tests++; if (cs_out !== 1'b1) begin fails++; $display("FAIL cs_latency: got %b want 1", cs_out); end
      for (int i = 0; i < 400 && !rx_valid; i++) @(negedge clk);
      tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL a5_rx_valid: got %b want 1", rx_valid); end
      tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL a5_rx_data: got %h want a5", rx_data); end
      tests++; if (rise_b.size() != NB) begin fails++; $display("FAIL a5_bit_count: got %0d want %0d", rise_b.size(), NB); end
      for (int k = 0; k < NB && k < rise_b.size(); k++) begin
         logic eb;
         eb = (k < 8) ? logic'((wv >> k) & 1) : logic'($countones(wv) % 2);
         tests++; if (rise_b[k] !== eb) begin fails++; $display("FAIL a5_sdo_bit%0d: got %b want %b", k, rise_b[k], eb); end
         if (k > 0) begin
            tests++; if (rise_t[k] - rise_t[k-1] != 8) begin
               fails++; $display("FAIL a5_bit_period%0d: got %0d want 8", k, rise_t[k] - rise_t[k-1]);
            end
         end
      end
      rx_rd = 1'b1; @(negedge clk); rx_rd = 1'b0;
      for (int i = 0; i < 100 && !tx_empty; i++) @(negedge clk);
      tick(3);
      tests++; if (irq_cnt != 1) begin fails++; $display("FAIL a5_irq_pulses: got %0d want 1", irq_cnt); end
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL a5_rx_drained: got %b want 0", rx_valid); end
      irq_en = 2'b00;
   endtask

   task automatic test_fill_17;
      int got = 0;
      loop = 1'b1; div = 8'd2; expq.delete();
      for (int i = 0; i < 17; i++) begin
         logic [7:0] w;
         w = 8'($urandom);
         expq.push_back(w);
         push(w);
      end
      tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL fill_tx_full: got %b want 1", tx_full); end
      push(8'($urandom));  // 18th word, must be lost
      tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL fill_tx_full_18: got %b want 1", tx_full); end
      for (int c = 0; c < 2000; c++) begin
         rx_rd = 1'b0;
         if (rx_valid) begin
            tests++;
            if (got >= 17 || rx_data !== expq[got]) begin
               fails++; $display("FAIL fill_word%0d: got %h want %h", got, rx_data, (got < 17) ? expq[got] : 8'hxx);
            end
            got++;
            rx_rd = 1'b1;
         end
         @(negedge clk);
      end
      rx_rd = 1'b0;
      tests++; if (got != 17) begin fails++; $display("FAIL fill_frame_count: got %0d want 17", got); end
      tests++; if (err !== 3'b000 || tx_empty !== 1'b1) begin
         fails++; $display("FAIL fill_end_state: got err=%b tx_empty=%b want 000/1", err, tx_empty);
      end
   endtask

   task automatic test_overflow;
      int got = 0;
      loop = 1'b1; div = 8'd2; expq.delete();
      for (int i = 0; i < 17; i++) begin
         logic [7:0] w;
         w = 8'($urandom);
         expq.push_back(w);
         push(w);
      end
      for (int i = 0; i < 2000 && !tx_empty; i++) @(negedge clk);
      tick(10);
      tests++; if (rx_valid !== 1'b1 || rx_data !== expq[0]) begin
         fails++; $display("FAIL ovr_first_word: got valid=%b %h want 1 %h", rx_valid, rx_data, expq[0]);
      end
      tests++; if (err !== 3'b001) begin fails++; $display("FAIL ovr_err: got %b want 001", err); end
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      tests++; if (err !== 3'b000) begin fails++; $display("FAIL ovr_err_clr: got %b want 000", err); end
      for (int i = 0; i < 20 && rx_valid; i++) begin
         tests++; if (rx_data !== expq[i]) begin fails++; $display("FAIL ovr_word%0d: got %h want %h", i, rx_data, expq[i]); end
         got++;
         rx_rd = 1'b1; @(negedge clk); rx_rd = 1'b0;
      end
      tests++; if (got != 16) begin fails++; $display("FAIL ovr_buffered: got %0d want 16", got); end
   endtask

   task automatic test_ext_frames;
      logic [7:0] w;
      loop = 1'b0;
      w = 8'($urandom);
      send_ext({7'd0, ^w, w}, NB);
      tests++; if (rx_valid !== 1'b1 || rx_data !== w) begin
         fails++; $display("FAIL ext_good: got valid=%b %h want 1 %h", rx_valid, rx_data, w);
      end
      tests++; if (err !== 3'b000) begin fails++; $display("FAIL ext_good_err: got %b want 000", err); end
      rx_rd = 1'b1; @(negedge clk); rx_rd = 1'b0;
      send_ext(16'h001F, 5);
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ext_short_push: got %b want 0", rx_valid); end
      tests++; if (err !== 3'b010) begin fails++; $display("FAIL ext_frm_err: got %b want 010", err); end
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      tests++; if (err !== 3'b000) begin fails++; $display("FAIL ext_err_clr: got %b want 000", err); end
`ifdef SERIAL_LINK_PARITY_EN
      send_ext(16'h0103, 9);
      tests++; if (rx_valid !== 1'b0 || err !== 3'b100) begin
         fails++; $display("FAIL par_bad: got valid=%b err=%b want 0 100", rx_valid, err);
      end
      send_ext(16'h0003, 9);
      tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h03) begin
         fails++; $display("FAIL par_good: got valid=%b %h want 1 03", rx_valid, rx_data);
      end
`endif
      // Leave a word and an error behind, then soft-reset the RX half.
      send_ext({7'd0, ^w, w}, NB);
      send_ext(16'h0007, 3);
      rx_rst = 1'b1; @(negedge clk); rx_rst = 1'b0;
      tests++; if (rx_valid !== 1'b0 || err !== 3'b000) begin
         fails++; $display("FAIL rx_rst: got valid=%b err=%b want 0 000", rx_valid, err);
      end
   endtask

   task automatic test_tx_rst;
      loop = 1'b0; div = 8'd3; irq_en = 2'b10;
      tick(3);
      irq_cnt = 0; rise_t.delete(); rise_b.delete();
      push(8'($urandom));
      push(8'($urandom));
      for (int i = 0; i < 200 && rise_t.size() < 3; i++) @(negedge clk);
      tests++; if (cs_out !== 1'b1) begin fails++; $display("FAIL txrst_in_frame: got cs=%b want 1", cs_out); end
      tx_rst = 1'b1; @(negedge clk); tx_rst = 1'b0;
      tests++; if (cs_out !== 1'b0 || sclk_out !== 1'b0) begin
         fails++; $display("FAIL txrst_lines: got cs=%b sclk=%b want 0 0", cs_out, sclk_out);
      end
      tests++; if (tx_empty !== 1'b1) begin fails++; $display("FAIL txrst_tx_empty: got %b want 1", tx_empty); end
      tick(40);
      tests++; if (cs_out !== 1'b0 || tx_empty !== 1'b1) begin
         fails++; $display("FAIL txrst_no_restart: got cs=%b tx_empty=%b want 0 1", cs_out, tx_empty);
      end
      tests++; if (irq_cnt != 1) begin fails++; $display("FAIL txrst_irq: got %0d want 1", irq_cnt); end
      irq_en = 2'b00;
   endtask

   initial begin
      test_reset();
      test_loopback_a5();
      test_fill_17();
      test_overflow();
      test_ext_frames();
      test_tx_rst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
